// File: rtl/nibble_serializer_if.sv
// Handshake bundle between the nibble serializer, its show-ahead FIFO and the serial sink.
interface nibble_serializer_if;
  localparam int unsigned NIBBLE_W = 4;

  logic                empty;
  logic [NIBBLE_W-1:0] read_data;
  logic                read_en;
  logic                ser_ready;
  logic                ser_valid;
  logic                ser_data;
  logic                ser_first;
  logic                ser_last;

  modport master (
    input  empty, read_data, ser_ready,
    output read_en, ser_valid, ser_data, ser_first, ser_last
  );

  modport slave (
    output empty, read_data, ser_ready,
    input  read_en, ser_valid, ser_data, ser_first, ser_last
  );
endinterface

// File: rtl/nibble_serializer.sv
// Pops nibbles from a show-ahead FIFO and emits them LSB first on a valid/ready bit stream,
// optionally followed by an even-parity bit; back-to-back frames carry no idle cycle.
module nibble_serializer #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                tx_en,
  nibble_serializer_if.master bus,
  output logic                busy,
  output logic [7:0]          frame_count
);

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned FRAME_W  = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NIBBLE_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NIBBLE_W-1:0]  shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;

  logic valid_c, data_c, first_c, last_c, xfer_c, pop_c;

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Output decode, pop decision and next-state logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    valid_c = 1'b0;
    data_c  = 1'b0;
    first_c = 1'b0;
    last_c  = 1'b0;

    case (state_q)
      DATA: begin
        valid_c = 1'b1;
        data_c  = shift_q[0];
        first_c = (cnt_q == CNT_W'(0));
        last_c  = !PARITY_EN && (cnt_q == LAST_BIT);
      end
      PAR: begin
        valid_c = 1'b1;
        data_c  = par_q;
        last_c  = 1'b1;
      end
      default: ;
    endcase

    xfer_c = valid_c && bus.ser_ready;
    // A new nibble may load either from idle or on the very edge that retires the last bit.
    pop_c  = rstN && tx_en && !bus.empty
             && ((state_q == IDLE) || (last_c && bus.ser_ready));

    if (xfer_c && last_c) begin
      frame_d = frame_q + FRAME_W'(1);
    end

    if (pop_c) begin
      shift_d = bus.read_data;
      par_d   = ^bus.read_data;
      cnt_d   = '0;
      state_d = DATA;
    end else begin
      case (state_q)
        IDLE: ;
        DATA: begin
          if (xfer_c) begin
            shift_d = {1'b0, shift_q[NIBBLE_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_d = PARITY_EN ? PAR : IDLE;
            end
          end
        end
        PAR: begin
          if (xfer_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.read_en   = pop_c;
  assign bus.ser_valid = valid_c;
  assign bus.ser_data  = data_c;
  assign bus.ser_first = first_c;
  assign bus.ser_last  = last_c;
  assign busy          = valid_c;
  assign frame_count   = frame_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: one parity and one no-parity instance, each fed by a FIFO model,
// with a frame-level scoreboard checking every cycle and directed/random scenarios on top.
module tb_nibble_serializer;

  localparam int unsigned FIFO_D = 1024;
  localparam int unsigned EXP_D  = 8192;

  logic       clk;
  logic       rstN;
  logic       tx_en;
  logic       busy0, busy1;
  logic [7:0] fc0, fc1;

  nibble_serializer_if bus0 ();
  nibble_serializer_if bus1 ();

  nibble_serializer #(.PARITY_EN(1'b1)) dut0 (
    .clk(clk), .rstN(rstN), .tx_en(tx_en), .bus(bus0), .busy(busy0), .frame_count(fc0)
  );
  nibble_serializer #(.PARITY_EN(1'b0)) dut1 (
    .clk(clk), .rstN(rstN), .tx_en(tx_en), .bus(bus1), .busy(busy1), .frame_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // FIFO contents per instance; pops[i] is the head index
  logic [3:0] fifo_mem [2][FIFO_D];
  int         ft   [2] = '{0, 0};
  int         pops [2] = '{0, 0};

  // Remaining expected bits of the frame in flight: {data, first, last}
  logic [2:0] exp_mem [2][EXP_D];
  int         eh  [2] = '{0, 0};
  int         et  [2] = '{0, 0};
  logic [7:0] cnt [2] = '{8'd0, 8'd0};

  logic rdy_val;
  bit   rdy_rand;

  logic cap_d [2][64];
  logic cap_f [2][64];
  logic cap_l [2][64];
  int   cap_n [2];

  logic       m_re, m_v, m_d, m_f, m_l, m_rdy, m_busy, m_exp_v, m_exp_re;
  logic [7:0] m_fc;
  logic [2:0] m_exp_bit, m_got_bit;
  logic [3:0] m_nib;
  int         m_rem;

  // Frame-level scoreboard: a frame is its four data bits LSB first, plus parity on instance 0.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        m_re = bus0.read_en; m_v = bus0.ser_valid; m_d = bus0.ser_data; m_f = bus0.ser_first;
        m_l = bus0.ser_last; m_rdy = bus0.ser_ready; m_fc = fc0; m_busy = busy0;
      end else begin
        m_re = bus1.read_en; m_v = bus1.ser_valid; m_d = bus1.ser_data; m_f = bus1.ser_first;
        m_l = bus1.ser_last; m_rdy = bus1.ser_ready; m_fc = fc1; m_busy = busy1;
      end
      if (!rstN) begin
        eh[i]  = et[i];
        cnt[i] = 8'd0;
      end
      m_rem     = et[i] - eh[i];
      m_exp_v   = (m_rem > 0);
      m_exp_re  = rstN && tx_en && (pops[i] < ft[i]) && ((m_rem == 0) || ((m_rem == 1) && m_rdy));
      m_exp_bit = m_exp_v ? exp_mem[i][eh[i]] : 3'b000;
      m_got_bit = {m_d, m_f, m_l};

      vectors++;
      if (m_re !== m_exp_re) begin
        miscompares++;
        $display("FAIL mon_read_en dut%0d t=%0t: got %b want %b", i, $time, m_re, m_exp_re);
      end
      vectors++;
      if ({m_v, m_busy} !== {m_exp_v, m_exp_v}) begin
        miscompares++;
        $display("FAIL mon_valid_busy dut%0d t=%0t: got %b%b want %b", i, $time, m_v, m_busy, m_exp_v);
      end
      vectors++;
      if (m_got_bit !== m_exp_bit) begin
        miscompares++;
        $display("FAIL mon_bit dut%0d t=%0t: got data/first/last %b want %b", i, $time, m_got_bit, m_exp_bit);
      end
      vectors++;
      if (m_fc !== cnt[i]) begin
        miscompares++;
        $display("FAIL mon_frame_count dut%0d t=%0t: got %0d want %0d", i, $time, m_fc, cnt[i]);
      end

      if (m_exp_v && m_rdy) begin
        if (m_exp_bit[0]) cnt[i] = cnt[i] + 8'd1;
        eh[i]++;
      end
      if (m_exp_re) begin
        m_nib = fifo_mem[i][pops[i]];
        for (int k = 0; k < 4; k++) begin
          exp_mem[i][et[i]] = {m_nib[k], (k == 0), ((k == 3) && (i == 1))};
          et[i]++;
        end
        if (i == 0) begin
          exp_mem[i][et[i]] = {^m_nib, 1'b0, 1'b1};
          et[i]++;
        end
        pops[i]++;
      end
    end
  end

  task automatic drive_fifo();
    bus0.empty     = (pops[0] >= ft[0]);
    bus0.read_data = bus0.empty ? 4'h0 : fifo_mem[0][pops[0]];
    bus1.empty     = (pops[1] >= ft[1]);
    bus1.read_data = bus1.empty ? 4'h0 : fifo_mem[1][pops[1]];
  endtask

  task automatic push_both(input logic [3:0] n);
    fifo_mem[0][ft[0]] = n; ft[0]++;
    fifo_mem[1][ft[1]] = n; ft[1]++;
    drive_fifo();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) rdy_val = 1'($urandom_range(0, 1));
    bus0.ser_ready = rdy_val;
    bus1.ser_ready = rdy_val;
    drive_fifo();
  endtask

  task automatic cap_clear();
    cap_n[0] = 0;
    cap_n[1] = 0;
  endtask

  // Advance one clock and record any bit that the next edge will transfer.
  task automatic cycle();
    tick();
    #1;
    if (bus0.ser_valid && bus0.ser_ready && cap_n[0] < 64) begin
      cap_d[0][cap_n[0]] = bus0.ser_data; cap_f[0][cap_n[0]] = bus0.ser_first;
      cap_l[0][cap_n[0]] = bus0.ser_last; cap_n[0]++;
    end
    if (bus1.ser_valid && bus1.ser_ready && cap_n[1] < 64) begin
      cap_d[1][cap_n[1]] = bus1.ser_data; cap_f[1][cap_n[1]] = bus1.ser_first;
      cap_l[1][cap_n[1]] = bus1.ser_last; cap_n[1]++;
    end
  endtask

  function automatic bit idle_now();
    return !bus0.ser_valid && !bus1.ser_valid && !bus0.read_en && !bus1.read_en;
  endfunction

  task automatic run_idle(input int max_c, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_c; c++) begin
      cycle();
      if (idle_now()) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // sel: 0 data, 1 first, 2 last; bit k of the result is the k-th captured bit
  function automatic logic [15:0] pack(input int i, input int sel);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < cap_n[i] && k < 16; k++) begin
      case (sel)
        0:       v[k] = cap_d[i][k];
        1:       v[k] = cap_f[i][k];
        default: v[k] = cap_l[i][k];
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    tx_en = 1'b1;
    rdy_val = 1'b1;
    push_both(4'b1011);
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      vectors++;
      if ({bus0.read_en, bus1.read_en} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_read_en: got %b want 00", {bus0.read_en, bus1.read_en});
      end
      vectors++;
      if ({bus0.ser_valid, bus1.ser_valid, busy0, busy1, bus0.ser_data, bus0.ser_first, bus0.ser_last} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b want 0000000",
                 {bus0.ser_valid, bus1.ser_valid, busy0, busy1, bus0.ser_data, bus0.ser_first, bus0.ser_last});
      end
      vectors++;
      if ({fc0, fc1} !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_frame_count: got %0d/%0d want 0/0", fc0, fc1);
      end
    end
    rstN = 1'b1;
  endtask

  task automatic test_single_frame();
    bit to;
    cap_clear();
    run_idle(30, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL single_timeout: got timeout want idle"); end
    vectors++;
    if ({cap_n[0], cap_n[1]} !== {32'd5, 32'd4}) begin
      miscompares++; $display("FAIL single_len: got %0d/%0d want 5/4", cap_n[0], cap_n[1]);
    end
    vectors++;
    if ({pack(0, 0), pack(0, 1), pack(0, 2)} !== {16'b11011, 16'b00001, 16'b10000}) begin
      miscompares++;
      $display("FAIL single_stream0: got d=%b f=%b l=%b want d=11011 f=00001 l=10000",
               pack(0, 0), pack(0, 1), pack(0, 2));
    end
    vectors++;
    if ({pack(1, 0), pack(1, 2)} !== {16'b1011, 16'b1000}) begin
      miscompares++;
      $display("FAIL single_stream1: got d=%b l=%b want d=1011 l=1000", pack(1, 0), pack(1, 2));
    end
    vectors++;
    if ({fc0, fc1} !== {8'd1, 8'd1}) begin
      miscompares++; $display("FAIL single_count: got %0d/%0d want 1/1", fc0, fc1);
    end
  endtask

  task automatic test_back_to_back();
    int coin0, coin1, gaps;
    bit to;
    coin0 = 0; coin1 = 0; gaps = 0; to = 1'b1;
    push_both(4'h3);
    push_both(4'hC);
    cap_clear();
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (bus0.read_en && bus0.ser_last && bus0.ser_ready) coin0++;
      if (bus1.read_en && bus1.ser_last && bus1.ser_ready) coin1++;
      if (cap_n[0] > 0 && cap_n[0] < 10 && !bus0.ser_valid) gaps++;
      if (idle_now()) begin to = 1'b0; break; end
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL b2b_timeout: got timeout want idle"); end
    vectors++;
    if ({cap_n[0], pack(0, 0)} !== {32'd10, 16'b0110000011}) begin
      miscompares++; $display("FAIL b2b_stream0: got n=%0d d=%b want n=10 d=0110000011", cap_n[0], pack(0, 0));
    end
    vectors++;
    if ({cap_n[1], pack(1, 0)} !== {32'd8, 16'b11000011}) begin
      miscompares++; $display("FAIL b2b_stream1: got n=%0d d=%b want n=8 d=11000011", cap_n[1], pack(1, 0));
    end
    vectors++;
    if ({coin0, coin1, gaps} !== {32'd1, 32'd1, 32'd0}) begin
      miscompares++; $display("FAIL b2b_overlap: got coin=%0d/%0d gaps=%0d want 1/1 0", coin0, coin1, gaps);
    end
    vectors++;
    if ({fc0, fc1} !== {8'd3, 8'd3}) begin
      miscompares++; $display("FAIL b2b_count: got %0d/%0d want 3/3", fc0, fc1);
    end
  endtask

  task automatic test_stall();
    int stall, held_bad, p0;
    bit to;
    stall = 0; held_bad = 0; to = 1'b1; p0 = pops[0];
    push_both(4'h5);
    cap_clear();
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (bus0.ser_valid && !bus0.ser_ready) begin
        stall++;
        if ({bus0.ser_data, bus0.ser_first, bus0.ser_last} !== 3'b000) held_bad++;
      end
      rdy_val = (cap_n[0] == 1 && stall < 3) ? 1'b0 : 1'b1;
      if (idle_now()) begin to = 1'b0; break; end
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL stall_timeout: got timeout want idle"); end
    vectors++;
    if ({stall, held_bad} !== {32'd3, 32'd0}) begin
      miscompares++; $display("FAIL stall_hold: got stalls=%0d bad=%0d want 3 0", stall, held_bad);
    end
    vectors++;
    if ({cap_n[0], pack(0, 0)} !== {32'd5, 16'b00101}) begin
      miscompares++; $display("FAIL stall_stream: got n=%0d d=%b want n=5 d=00101", cap_n[0], pack(0, 0));
    end
    vectors++;
    if (pops[0] - p0 !== 1 || fc0 !== 8'd4) begin
      miscompares++; $display("FAIL stall_pops: got pops=%0d count=%0d want 1 4", pops[0] - p0, fc0);
    end
  endtask

  task automatic test_no_parity();
    bit to;
    push_both(4'hA);
    cap_clear();
    run_idle(30, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL nopar_timeout: got timeout want idle"); end
    vectors++;
    if ({cap_n[1], pack(1, 0), pack(1, 1), pack(1, 2)} !== {32'd4, 16'b1010, 16'b0001, 16'b1000}) begin
      miscompares++;
      $display("FAIL nopar_stream: got n=%0d d=%b f=%b l=%b want n=4 d=1010 f=0001 l=1000",
               cap_n[1], pack(1, 0), pack(1, 1), pack(1, 2));
    end
    vectors++;
    if ({cap_n[0], pack(0, 0)} !== {32'd5, 16'b01010}) begin
      miscompares++; $display("FAIL par_stream_A: got n=%0d d=%b want n=5 d=01010", cap_n[0], pack(0, 0));
    end
    vectors++;
    if ({fc0, fc1} !== {8'd5, 8'd5}) begin
      miscompares++; $display("FAIL nopar_count: got %0d/%0d want 5/5", fc0, fc1);
    end
  endtask

  task automatic test_tx_en_drop();
    int re_after;
    bit dropped, to;
    re_after = 0; dropped = 1'b0; to = 1'b1;
    push_both(4'h6);
    push_both(4'h9);
    cap_clear();
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (dropped && (bus0.read_en || bus1.read_en)) re_after++;
      if (!dropped && cap_n[0] == 1) begin
        tx_en = 1'b0;
        dropped = 1'b1;
      end
      if (dropped && idle_now()) begin to = 1'b0; break; end
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL txdrop_timeout: got timeout want idle"); end
    vectors++;
    if ({cap_n[0], pack(0, 0), re_after} !== {32'd5, 16'b00110, 32'd0}) begin
      miscompares++;
      $display("FAIL txdrop_frame: got n=%0d d=%b reads=%0d want n=5 d=00110 reads=0", cap_n[0], pack(0, 0), re_after);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      vectors++;
      if ({bus0.read_en, bus0.ser_valid, bus1.read_en, bus1.ser_valid} !== 4'b0000) begin
        miscompares++;
        $display("FAIL txdrop_idle: got re/valid %b want 0000",
                 {bus0.read_en, bus0.ser_valid, bus1.read_en, bus1.ser_valid});
      end
    end
    tx_en = 1'b1;
    cap_clear();
    run_idle(30, to);
    vectors++;
    if (to || {cap_n[0], pack(0, 0)} !== {32'd5, 16'b01001}) begin
      miscompares++;
      $display("FAIL txdrop_resume: got to=%0d n=%0d d=%b want to=0 n=5 d=01001", to, cap_n[0], pack(0, 0));
    end
    vectors++;
    if ({fc0, fc1} !== {8'd7, 8'd7}) begin
      miscompares++; $display("FAIL txdrop_count: got %0d/%0d want 7/7", fc0, fc1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    push_both(4'hE);
    push_both(4'h9);
    cap_clear();
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (cap_n[0] == 3) break;
    end
    rstN = 1'b0;
    #1;
    vectors++;
    if ({bus0.ser_valid, bus1.ser_valid, busy0, busy1, bus0.read_en, bus1.read_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b want 000000",
               {bus0.ser_valid, bus1.ser_valid, busy0, busy1, bus0.read_en, bus1.read_en});
    end
    vectors++;
    if ({fc0, fc1} !== 16'h0000) begin
      miscompares++; $display("FAIL rstmid_count: got %0d/%0d want 0/0", fc0, fc1);
    end
    tick();
    tick();
    rstN = 1'b1;
    cap_clear();
    run_idle(30, to);
    vectors++;
    if (to || {cap_n[0], pack(0, 0)} !== {32'd5, 16'b01001}) begin
      miscompares++;
      $display("FAIL rstmid_resume0: got to=%0d n=%0d d=%b want to=0 n=5 d=01001", to, cap_n[0], pack(0, 0));
    end
    vectors++;
    if ({cap_n[1], pack(1, 0)} !== {32'd4, 16'b1001}) begin
      miscompares++; $display("FAIL rstmid_resume1: got n=%0d d=%b want n=4 d=1001", cap_n[1], pack(1, 0));
    end
    vectors++;
    if ({fc0, fc1} !== {8'd1, 8'd1}) begin
      miscompares++; $display("FAIL rstmid_count_after: got %0d/%0d want 1/1", fc0, fc1);
    end
  endtask

  task automatic test_random(output int npush);
    bit to;
    npush = 0;
    rdy_rand = 1'b1;
    for (int c = 0; c < 300; c++) begin
      cycle();
      if ($urandom_range(0, 2) == 0 && (ft[0] - pops[0]) < 8) begin
        push_both(4'($urandom_range(0, 15)));
        npush++;
      end
      if ($urandom_range(0, 15) == 0) tx_en = ~tx_en;
    end
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    tx_en = 1'b1;
    run_idle(200, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL random_timeout: got timeout want idle"); end
    vectors++;
    if ({fc0, fc1} !== {8'(1 + npush), 8'(1 + npush)}) begin
      miscompares++;
      $display("FAIL random_count: got %0d/%0d want %0d", fc0, fc1, 8'(1 + npush));
    end
  endtask

  task automatic test_wrap(input logic [7:0] start);
    bit to;
    for (int k = 0; k < 260; k++) push_both(4'($urandom_range(0, 15)));
    run_idle(2000, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL wrap_timeout: got timeout want idle"); end
    vectors++;
    if ({fc0, fc1} !== {8'(start + 8'd4), 8'(start + 8'd4)}) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d/%0d want %0d", fc0, fc1, 8'(start + 8'd4));
    end
  endtask

  initial begin
    int npush;
    rstN = 1'b1;
    tx_en = 1'b0;
    rdy_val = 1'b0;
    rdy_rand = 1'b0;
    bus0.ser_ready = 1'b0;
    bus1.ser_ready = 1'b0;
    drive_fifo();
    #2 rstN = 1'b0;

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_no_parity();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_random(npush);
    test_wrap(8'(1 + npush));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = each frame carries 4 data bits plus an even-parity bit; 0 = each frame carries 4 data bits only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstN  input  1  reset, asynchronous, active-low.
REQ-004 tx_en  input  1  1 = permit popping new nibbles from the FIFO.
REQ-005 empty  input  1  FIFO empty flag.
REQ-006 read_data  input  4  FIFO head nibble, show-ahead: valid in the same cycle while empty=0.
REQ-007 read_en  output  1  FIFO pop strobe, combinational; a pop occurs on the clk edge where read_en=1.
REQ-008 ser_ready  input  1  downstream accepts the current bit.
REQ-009 ser_valid  output  1  ser_data holds a valid bit.
REQ-010 ser_data  output  1  serial bit, LSB first.
REQ-011 ser_first  output  1  current bit is data bit 0 of a frame.
REQ-012 ser_last  output  1  current bit is the final bit of a frame.
REQ-013 busy  output  1  frame in progress (equals ser_valid).
REQ-014 frame_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 The FSM SHALL have 3 states: IDLE, DATA, PAR (PAR is unreachable when PARITY_EN=0).
REQ-016 A bit transfer SHALL occur only on a clk edge with ser_valid=1 and ser_ready=1.
REQ-017 read_en SHALL be 1 iff rstN=1, tx_en=1, empty=0, and either (state=IDLE) or (ser_last=1 and ser_ready=1).
REQ-018 On a pop edge: shift register <= read_data; parity register <= XOR of read_data; bit counter <= 0; state <= DATA.
REQ-019 In DATA: ser_data = shift register bit 0; ser_first = (bit counter=0); on each transfer, shift right by 1 and increment the bit counter.
REQ-020 A transfer in DATA with bit counter=3 SHALL go to PAR if PARITY_EN=1; if PARITY_EN=0, it SHALL complete the frame.
REQ-021 In PAR: ser_data = parity register; ser_last = 1; a transfer completes the frame.
REQ-022 ser_last SHALL be 1 in DATA with bit counter=3 only when PARITY_EN=0.
REQ-023 On frame completion: frame_count increments by 1 (mod 256). State goes to DATA if a pop occurs on that same edge (back-to-back, zero idle cycles); otherwise state goes to IDLE.
REQ-024 ser_valid SHALL be 1 in DATA and PAR, and 0 in IDLE. ser_data, ser_first and ser_last SHALL be 0 in IDLE.
REQ-025 While ser_ready=0, the state, shift register, bit counter and all ser_* outputs SHALL hold unchanged.
REQ-026 Deasserting tx_en mid-frame SHALL NOT abort the frame; the frame completes, then the block stays in IDLE.
REQ-027 empty=1 at frame end SHALL return the block to IDLE without a pop; read_en SHALL never be 1 while empty=1.
REQ-028 Frame length SHALL be 5 transfers with PARITY_EN=1 and 4 transfers with PARITY_EN=0. Minimum latency from pop edge to first bit is 0 cycles: ser_valid=1 in the cycle after the pop edge.

Reset
REQ-029 While rstN=0: state=IDLE; shift register, parity register and bit counter = 0; frame_count=0; ser_valid, ser_data, ser_first, ser_last, busy = 0; read_en=0.
REQ-030 rstN assertion mid-frame SHALL discard the frame immediately, with no pop and no frame_count increment. After release, operation resumes from IDLE on the next edge.

Verification
REQ-031 FIFO head=4'b1011, tx_en=1, ser_ready=1 -> one pop, then ser_data 1,1,0,1,1 (parity=1); ser_first on bit 1, ser_last on bit 5; frame_count=1.
REQ-032 Two queued nibbles, 4'h3 then 4'hC, ser_ready=1 -> 10 consecutive valid bits 1,1,0,0,0, 0,0,1,1,0; second read_en coincides with the first frame's parity transfer; ser_valid never drops; frame_count=2.
REQ-033 ser_ready=0 for 3 cycles on bit 2 of nibble 4'h5 -> ser_data holds 0 for those 3 cycles; complete stream 1,0,1,0,0; no extra pop.
REQ-034 tx_en dropped after bit 1 with 2 nibbles queued -> current frame finishes; read_en stays 0; block idles in IDLE with FIFO holding 1 nibble.
REQ-035 rstN pulsed low during bit 3 -> ser_valid=0 asynchronously; frame_count=0; no pop during reset; next nibble serializes normally after release.
REQ-036 PARITY_EN=0, nibble 4'hA -> bits 0,1,0,1, with ser_last on bit 4; frame_count=1.
